pb_queue_ctrl: RTL and testbench

PB_QUEUE_CTRL -- requirements
Module: pb_queue_ctrl

---
 rtl/pb_queue_ctrl_if.sv | 54 +++++
 rtl/pb_queue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pb_queue_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pb_queue_ctrl_if.sv
// Packet-buffer queue controller bus: upstream byte strobe, packet-buffer
// write port and downstream transmitter handshake.
// Optional: PB_QUEUE_DROP_STATS_EN adds the 16-bit drop_cnt signal.
interface pb_queue_ctrl_if #(
    parameter int RAM_SIZE = 4096,
    parameter int PKT_LEN  = 1000
);
    localparam int PW = $clog2(PKT_LEN);
    localparam int P  = 1 << PW;
    localparam int Q  = RAM_SIZE / P;
    localparam int QW = $clog2(Q);
    localparam int AW = $clog2(RAM_SIZE);

    // upstream byte receiver
    logic          inclk;
    logic [7:0]    in;
    // packet-buffer write port
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_win;
    // downstream transmitter
    logic          tx_start;
    logic [AW-1:0] tx_read_start;
    logic [AW:0]   tx_read_end;
    logic          tx_done;
    // status
    logic [QW-1:0] occupancy;
    logic          tx_busy;
`ifdef PB_QUEUE_DROP_STATS_EN
    logic [15:0]   drop_cnt;
`endif

    // controller side
    modport master (
        input  inclk, in, tx_done,
        output ram_we, ram_waddr, ram_win,
        output tx_start, tx_read_start, tx_read_end,
        output occupancy, tx_busy
`ifdef PB_QUEUE_DROP_STATS_EN
        , output drop_cnt
`endif
    );

    // environment side (byte source, buffer RAM, transmitter)
    modport slave (
        output inclk, in, tx_done,
        input  ram_we, ram_waddr, ram_win,
        input  tx_start, tx_read_start, tx_read_end,
        input  occupancy, tx_busy
`ifdef PB_QUEUE_DROP_STATS_EN
        , input drop_cnt
`endif
    );
endinterface

// File: rtl/pb_queue_ctrl.sv
// Packet-buffer queue controller.
// Incoming bytes are written into fixed-size slots of a packet RAM; each
// completed packet is committed to a circular queue of Q slots and handed
// to the downstream transmitter one at a time.
// Optional: define PB_QUEUE_DROP_STATS_EN to add a saturating drop counter.
module pb_queue_ctrl #(
    parameter int RAM_SIZE     = 4096,
    parameter int PKT_LEN      = 1000,
    parameter int IDLE_TIMEOUT = 50000
) (
    input logic           clk,
    input logic           rst,
    pb_queue_ctrl_if.master bus
);
    localparam int PW = $clog2(PKT_LEN);          // byte offset bits in a slot
    localparam int P  = 1 << PW;                  // slot (partition) size
    localparam int Q  = RAM_SIZE / P;             // slot count
    localparam int QW = $clog2(Q);                // slot pointer bits
    localparam int AW = $clog2(RAM_SIZE);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [PW-1:0] CNT_LAST  = PW'(PKT_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [AW:0]   LEN_EXT   = (AW+1)'(PKT_LEN);

    // TX state encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    logic [PW-1:0] cnt;
    logic [QW-1:0] head;
    logic [QW-1:0] tail;
    logic [QW-1:0] tail_inc;
    logic [QW-1:0] head_inc;
    logic [IW-1:0] idle_cnt;
    logic [1:0]    state;

    logic          ram_we_q;
    logic [AW-1:0] ram_waddr_q;
    logic [7:0]    ram_win_q;

    logic last_byte;
    logic full;
    logic commit;
    logic drop;
    logic tx_pop;
    logic idle_hit;

    assign tail_inc  = tail + 1'b1;
    assign head_inc  = head + 1'b1;

    // A slot is only committed while at least one slot stays free, so the
    // writer can never reach the slot the transmitter is reading.
    assign last_byte = bus.inclk && (cnt == CNT_LAST);
    assign full      = (tail_inc == head);
    assign commit    = last_byte && !full;
    assign drop      = last_byte && full;
    assign tx_pop    = (state == S_ACTIVE) && bus.tx_done;

    // Fires on the cycle the idle counter reaches IDLE_TIMEOUT.
    assign idle_hit  = !bus.inclk && (idle_cnt == IDLE_LAST);

    // Idle counter: restarts on each byte, saturates at the timeout value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (bus.inclk)
            idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
    end

    // Byte-in-packet counter; a stalled partial packet is abandoned on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (bus.inclk)
            cnt <= last_byte ? '0 : cnt + 1'b1;
        else if (idle_hit && cnt != '0)
            cnt <= '0;
    end

    // Tail pointer: advances only on a committed packet. A dropped packet
    // leaves tail alone so the next packet overwrites the same slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tail <= '0;
        else if (commit)
            tail <= tail_inc;
    end

    // Head pointer: advances when the transmitter finishes the head packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            head <= '0;
        else if (tx_pop)
            head <= head_inc;
    end

    // Registered packet-buffer write port (one cycle behind the byte strobe).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_win_q   <= '0;
        end else begin
            ram_we_q <= bus.inclk;
            if (bus.inclk) begin
                ram_waddr_q <= {tail, cnt};
                ram_win_q   <= bus.in;
            end
        end
    end

    // TX launcher: one-cycle START pulse, then wait for tx_done in ACTIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else begin
            case (state)
                S_IDLE:   if (head != tail) state <= S_START;
                S_START:  state <= S_ACTIVE;
                S_ACTIVE: if (bus.tx_done) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef PB_QUEUE_DROP_STATS_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of packets discarded because the queue was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 1'b1;
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign bus.ram_we        = ram_we_q;
    assign bus.ram_waddr     = ram_waddr_q;
    assign bus.ram_win       = ram_win_q;

    // head only moves on ACTIVE exit, so the read window is stable for the
    // whole START/ACTIVE span.
    assign bus.tx_start      = (state == S_START);
    assign bus.tx_busy       = (state == S_START) || (state == S_ACTIVE);
    assign bus.tx_read_start = {head, {PW{1'b0}}};
    assign bus.tx_read_end   = {1'b0, bus.tx_read_start} + LEN_EXT;

    // Q is a power of two, so plain subtraction wraps modulo Q.
    assign bus.occupancy     = tail - head;

endmodule

// File: tb/tb_pb_queue_ctrl.sv
// Directed bench for pb_queue_ctrl with PKT_LEN=4, RAM_SIZE=16 (Q=4),
// IDLE_TIMEOUT=20. Expected values are hand-computed constants.
module tb_pb_queue_ctrl;
    localparam int RAM_SIZE     = 16;
    localparam int PKT_LEN      = 4;
    localparam int IDLE_TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    pb_queue_ctrl_if #(.RAM_SIZE(RAM_SIZE), .PKT_LEN(PKT_LEN)) bus ();

    pb_queue_ctrl #(
        .RAM_SIZE    (RAM_SIZE),
        .PKT_LEN     (PKT_LEN),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock, land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int exp_addr);
        bus.inclk = 1'b1;
        bus.in    = b;
        tick();
        bus.inclk = 1'b0;
        chk("ram_we", {31'd0, bus.ram_we}, 1);
        chk("ram_waddr", {28'd0, bus.ram_waddr}, exp_addr);
        chk("ram_win", {24'd0, bus.ram_win}, {24'd0, b});
    endtask

    task automatic send_pkt(input logic [7:0] base, input int exp_base);
        for (int i = 0; i < PKT_LEN; i++)
            send_byte(base + 8'(i), exp_base + i);
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int exp_rs [6];
        int seen;
        exp_rs = '{0, 4, 8, 12, 0, 4};
        bus.inclk   = 1'b0;
        bus.in      = 8'h00;
        bus.tx_done = 1'b0;

        // ---- reset state
        do_reset();
        chk("rst_ram_we", {31'd0, bus.ram_we}, 0);
        chk("rst_waddr", {28'd0, bus.ram_waddr}, 0);
        chk("rst_occ", {30'd0, bus.occupancy}, 0);
        chk("rst_busy", {31'd0, bus.tx_busy}, 0);
        chk("rst_start", {31'd0, bus.tx_start}, 0);
`ifdef PB_QUEUE_DROP_STATS_EN
        chk("rst_drop", {16'd0, bus.drop_cnt}, 0);
`endif

        // tx_done in IDLE must not move head
        pulse_done();
        chk("idle_done_occ", {30'd0, bus.occupancy}, 0);

        // ---- basic write and launch
        send_pkt(8'hA0, 0);
        chk("basic_occ", {30'd0, bus.occupancy}, 1);
        tick();
        chk("basic_we_low", {31'd0, bus.ram_we}, 0);
        chk("basic_start", {31'd0, bus.tx_start}, 1);
        chk("basic_rs", {28'd0, bus.tx_read_start}, 0);
        chk("basic_re", {27'd0, bus.tx_read_end}, 4);
        // tx_done during START is ignored
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("start_done_busy", {31'd0, bus.tx_busy}, 1);
        chk("start_done_occ", {30'd0, bus.occupancy}, 1);
        chk("start_pulse_len", {31'd0, bus.tx_start}, 0);
        pulse_done();
        chk("basic_pop_occ", {30'd0, bus.occupancy}, 0);
        chk("basic_pop_busy", {31'd0, bus.tx_busy}, 0);

        // ---- full queue and drop
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_pkt(8'h10 * 8'(k), 4 * k);
            chk("full_occ", {30'd0, bus.occupancy}, (k < 3) ? k + 1 : 3);
        end
        chk("full_busy", {31'd0, bus.tx_busy}, 1);
        chk("full_rs", {28'd0, bus.tx_read_start}, 0);
`ifdef PB_QUEUE_DROP_STATS_EN
        chk("drop_cnt1", {16'd0, bus.drop_cnt}, 1);
`endif
        // dropped slot is reused by the next packet
        send_pkt(8'h50, 12);
        chk("full_occ2", {30'd0, bus.occupancy}, 3);
`ifdef PB_QUEUE_DROP_STATS_EN
        chk("drop_cnt2", {16'd0, bus.drop_cnt}, 2);
`endif

        // ---- idle timeout
        do_reset();
        send_byte(8'h61, 0);
        send_byte(8'h62, 1);
        for (int i = 0; i < 22; i++) tick();
        chk("to_occ0", {30'd0, bus.occupancy}, 0);
        send_pkt(8'h70, 0);
        chk("to_occ1", {30'd0, bus.occupancy}, 1);

        // ---- simultaneous commit and head advance
        do_reset();
        send_pkt(8'h10, 0);
        tick();
        chk("sim_start", {31'd0, bus.tx_start}, 1);
        tick();
        chk("sim_active", {31'd0, bus.tx_busy}, 1);
        send_byte(8'h20, 4);
        send_byte(8'h21, 5);
        send_byte(8'h22, 6);
        chk("sim_occ_pre", {30'd0, bus.occupancy}, 1);
        bus.inclk   = 1'b1;
        bus.in      = 8'h23;
        bus.tx_done = 1'b1;
        tick();
        bus.inclk   = 1'b0;
        bus.tx_done = 1'b0;
        chk("sim_waddr", {28'd0, bus.ram_waddr}, 7);
        chk("sim_occ_post", {30'd0, bus.occupancy}, 1);
        chk("sim_idle", {31'd0, bus.tx_busy}, 0);
        tick();
        chk("sim_start2", {31'd0, bus.tx_start}, 1);
        chk("sim_rs2", {28'd0, bus.tx_read_start}, 4);
        chk("sim_re2", {27'd0, bus.tx_read_end}, 8);

        // ---- wrap-around
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send_pkt(8'h80 + 8'(k * 4), exp_rs[k]);
            tick();
            chk("wrap_start", {31'd0, bus.tx_start}, 1);
            chk("wrap_rs", {28'd0, bus.tx_read_start}, exp_rs[k]);
            chk("wrap_re", {27'd0, bus.tx_read_end}, exp_rs[k] + 4);
            tick();
            pulse_done();
            chk("wrap_occ", {30'd0, bus.occupancy}, 0);
        end

        // ---- reset mid-operation
        do_reset();
        send_pkt(8'hC0, 0);
        send_pkt(8'hD0, 4);
        chk("mid_occ", {30'd0, bus.occupancy}, 2);
        chk("mid_busy", {31'd0, bus.tx_busy}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", {31'd0, bus.ram_we}, 0);
        chk("mid_rst_waddr", {28'd0, bus.ram_waddr}, 0);
        chk("mid_rst_occ", {30'd0, bus.occupancy}, 0);
        chk("mid_rst_busy", {31'd0, bus.tx_busy}, 0);
        chk("mid_rst_start", {31'd0, bus.tx_start}, 0);
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.tx_start) seen++;
        end
        chk("mid_no_start", seen, 0);
        send_pkt(8'hE0, 0);
        tick();
        chk("mid_new_start", {31'd0, bus.tx_start}, 1);
        chk("mid_new_rs", {28'd0, bus.tx_read_start}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
